// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and data ports onto one memory port with ack timeout
// Define MEM_ARB_RR_EN for round-robin grant on simultaneous requests (default: data port wins).
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_hit_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [3:0]  dm_be_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_hit_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, DONE} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] wait_q;
  logic        cmd_we_q;
  logic [31:0] cmd_addr_q, cmd_wdata_q;
  logic [3:0]  cmd_be_q;
  logic        sel_dm_q;
  logic        err_q;
  logic [31:0] if_data_q, dm_rdata_q;
  logic        grant_dm, grant_if, in_acc, expired;

`ifdef MEM_ARB_RR_EN
  logic last_dm_q;

  // On a tie the port that was not granted last wins; reset value favours data first.
  assign grant_dm = dm_req_i && (!if_req_i || !last_dm_q);
`else
  assign grant_dm = dm_req_i;
`endif
  assign grant_if = if_req_i && !grant_dm;

  assign in_acc  = (state_q == IF_ACC) || (state_q == DM_ACC);
  assign expired = in_acc && !mem_ack_i && (wait_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_dm)      state_d = DM_ACC;
        else if (grant_if) state_d = IF_ACC;
      end
      IF_ACC, DM_ACC: begin
        if (mem_ack_i || expired) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q      <= '0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= 32'h0;
      cmd_wdata_q <= 32'h0;
      cmd_be_q    <= 4'h0;
      sel_dm_q    <= 1'b0;
      err_q       <= 1'b0;
      if_data_q   <= 32'h0;
      dm_rdata_q  <= 32'h0;
`ifdef MEM_ARB_RR_EN
      last_dm_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_dm || grant_if) begin
            wait_q   <= '0;
            err_q    <= 1'b0;
            sel_dm_q <= grant_dm;
`ifdef MEM_ARB_RR_EN
            last_dm_q <= grant_dm;
`endif
          end
          if (grant_dm) begin
            cmd_we_q    <= dm_we_i;
            cmd_addr_q  <= dm_addr_i;
            cmd_wdata_q <= dm_wdata_i;
            cmd_be_q    <= dm_be_i;
          end else if (grant_if) begin
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= if_addr_i;
            cmd_wdata_q <= 32'h0;
            cmd_be_q    <= 4'hF;
          end
        end
        IF_ACC, DM_ACC: begin
          // A store completion leaves the load data register untouched.
          if (mem_ack_i) begin
            if (state_q == IF_ACC)  if_data_q  <= mem_rdata_i;
            else if (!cmd_we_q)     dm_rdata_q <= mem_rdata_i;
          end else if (expired) begin
            err_q <= 1'b1;
            if (state_q == IF_ACC) if_data_q  <= 32'h0;
            else                   dm_rdata_q <= 32'h0;
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req_o   = in_acc;
  assign mem_we_o    = cmd_we_q;
  assign mem_addr_o  = cmd_addr_q;
  assign mem_wdata_o = cmd_wdata_q;
  assign mem_be_o    = cmd_be_q;
  assign if_data_o   = if_data_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_hit_o    = (state_q == DONE) && !sel_dm_q;
  assign dm_hit_o    = (state_q == DONE) && sel_dm_q;
  assign err_o       = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (default fixed-priority build)
module tb_mem_arbiter;
  localparam int TMO = 64;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          start;
    int          len;
    int          delay;
    logic [31:0] rdata;
  } cmd_t;

  typedef struct {
    logic        dm;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } hit_t;

  logic        clk, rst_i;
  logic        if_req_i, dm_req_i, dm_we_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i;
  logic [3:0]  dm_be_i;
  logic [31:0] if_data_o, dm_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        if_hit_o, dm_hit_o, mem_req_o, mem_we_o, mem_ack_i, err_o;
  logic [3:0]  mem_be_o;

  logic        resp_ack, manual_ack;
  logic [31:0] resp_data, manual_data;
  assign mem_ack_i   = resp_ack | manual_ack;
  assign mem_rdata_i = manual_ack ? manual_data : resp_data;

  cmd_t cmdq[$];
  hit_t hitq[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_hit_o(if_hit_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_be_i(dm_be_i), .dm_rdata_o(dm_rdata_o), .dm_hit_o(dm_hit_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: serves each access with the delay and data its scoreboard entry carries.
  cmd_t cur;
  int   cnt = 0;
  bit   active = 0;
  always @(negedge clk) begin
    if (mem_req_o) begin
      if (!active) begin
        active = 1;
        cnt = 0;
        if (cmdq.size() == 0) begin
          chk("unexpected_access", mem_addr_o, 32'hFFFF_FFFF);
          cur = '{addr: mem_addr_o, we: mem_we_o, wdata: mem_wdata_o, be: mem_be_o,
                  start: cyc, len: -1, delay: -1, rdata: 32'h0};
        end else begin
          cur = cmdq.pop_front();
          chk("req_start_cycle", cyc, cur.start);
        end
      end
      chk("mem_addr", mem_addr_o, cur.addr);
      chk("mem_we", {31'h0, mem_we_o}, {31'h0, cur.we});
      chk("mem_be", {28'h0, mem_be_o}, {28'h0, cur.be});
      if (cur.we) chk("mem_wdata", mem_wdata_o, cur.wdata);
      if (cur.delay >= 0 && cnt == cur.delay) begin
        resp_ack  = 1'b1;
        resp_data = cur.rdata;
      end else begin
        resp_ack  = 1'b0;
        resp_data = 32'hBAD0_BAD0;
      end
      cnt++;
    end else begin
      resp_ack = 1'b0;
      if (active) begin
        active = 0;
        if (cur.len >= 0) chk("req_length", cnt, cur.len);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_i) begin
      if (if_hit_o && dm_hit_o) chk("both_hits", 32'h1, 32'h0);
      if (err_o && !if_hit_o && !dm_hit_o) chk("err_without_hit", 32'h1, 32'h0);
      if (if_hit_o || dm_hit_o) begin
        if (hitq.size() == 0) begin
          chk("unexpected_hit", {30'h0, dm_hit_o, if_hit_o}, 32'h0);
        end else begin
          hit_t e;
          e = hitq.pop_front();
          chk("hit_port_dm", {31'h0, dm_hit_o}, {31'h0, e.dm});
          chk("hit_data", e.dm ? dm_rdata_o : if_data_o, e.data);
          chk("hit_err", {31'h0, err_o}, {31'h0, e.err});
          chk("hit_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_hits(input int n);
    int got = 0;
    for (int i = 0; i < 300 && got < n; i++) begin
      @(negedge clk);
      if (dm_hit_o) begin dm_req_i = 1'b0; got++; end
      if (if_hit_o) begin if_req_i = 1'b0; got++; end
    end
    chk("hit_wait", got, n);
  endtask

  task automatic push_cmd(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [3:0] be, input int start, input int delay,
                          input logic [31:0] rdata);
    cmd_t c;
    c.addr = addr; c.we = we; c.wdata = wdata; c.be = be; c.start = start;
    c.delay = delay; c.len = (delay < 0) ? TMO : delay + 1; c.rdata = rdata;
    cmdq.push_back(c);
  endtask

  task automatic push_hit(input logic dm, input logic [31:0] data, input logic err, input int at);
    hit_t h;
    h.dm = dm; h.data = data; h.err = err; h.cyc = at;
    hitq.push_back(h);
  endtask

  task automatic do_acc(input bit dm, input logic [31:0] addr, input logic we,
                        input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] rdata,
                        input int delay, input logic [31:0] exp_data, input bit withdraw);
    int n;
    @(negedge clk);
    n = cyc;
    if (dm) begin
      dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = addr; dm_wdata_i = wdata; dm_be_i = be;
      push_cmd(addr, we, wdata, be, n + 1, delay, rdata);
    end else begin
      if_req_i = 1'b1; if_addr_i = addr;
      push_cmd(addr, 1'b0, 32'h0, 4'hF, n + 1, delay, rdata);
    end
    push_hit(dm, exp_data, delay < 0, (delay < 0) ? n + 1 + TMO : n + 2 + delay);
    if (withdraw) begin
      @(negedge clk);
      if_req_i = 1'b0; dm_req_i = 1'b0;
      if_addr_i = 32'hFFFF_FFFF; dm_addr_i = 32'hFFFF_FFFF;
    end
    wait_hits(1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mem_req"},  {31'h0, mem_req_o}, 32'h0);
    chk({tag, "_mem_we"},   {31'h0, mem_we_o}, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
    chk({tag, "_mem_be"},   {28'h0, mem_be_o}, 32'h0);
    chk({tag, "_if_hit"},   {31'h0, if_hit_o}, 32'h0);
    chk({tag, "_dm_hit"},   {31'h0, dm_hit_o}, 32'h0);
    chk({tag, "_err"},      {31'h0, err_o}, 32'h0);
    chk({tag, "_if_data"},  if_data_o, 32'h0);
    chk({tag, "_dm_rdata"}, dm_rdata_o, 32'h0);
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0; dm_be_i = 4'h0;
    resp_ack = 1'b0; resp_data = 32'h0; manual_ack = 1'b0; manual_data = 32'h0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_i = 1'b0;

    do_acc(1'b0, 32'h100, 1'b0, 32'h0, 4'h0, 32'h0050_0093, 1, 32'h0050_0093, 1'b0);
    do_acc(1'b1, 32'h40, 1'b0, 32'h0, 4'hF, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0);
    do_acc(1'b1, 32'h2000, 1'b1, 32'hDEAD_BEEF, 4'h3, 32'h1234_5678, 3, 32'hCAFE_F00D, 1'b0);
    chk("if_data_held", if_data_o, 32'h0050_0093);

    // Simultaneous requests: data first, fetch granted from the following IDLE cycle.
    @(negedge clk);
    n = cyc;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h44; dm_be_i = 4'hF;
    if_req_i = 1'b1; if_addr_i = 32'h104;
    push_cmd(32'h44, 1'b0, 32'h0, 4'hF, n + 1, 1, 32'h1111_1111);
    push_cmd(32'h104, 1'b0, 32'h0, 4'hF, n + 5, 1, 32'h2222_2222);
    push_hit(1'b1, 32'h1111_1111, 1'b0, n + 3);
    push_hit(1'b0, 32'h2222_2222, 1'b0, n + 7);
    wait_hits(2);

    do_acc(1'b0, 32'h108, 1'b0, 32'h0, 4'h0, 32'h3333_3333, 4, 32'h3333_3333, 1'b1);
    do_acc(1'b1, 32'h48, 1'b0, 32'h0, 4'hF, 32'h0, -1, 32'h0, 1'b0);
    chk("if_data_after_timeout", if_data_o, 32'h3333_3333);

    // Reset in the middle of a data access, then a stray ack.
    @(negedge clk);
    n = cyc;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h4C; dm_be_i = 4'hF;
    cmdq.push_back('{addr: 32'h4C, we: 1'b0, wdata: 32'h0, be: 4'hF, start: n + 1,
                     len: -1, delay: -1, rdata: 32'h0});
    repeat (5) @(negedge clk);
    chk("mem_req_before_rst", {31'h0, mem_req_o}, 32'h1);
    rst_i = 1'b1; dm_req_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    check_reset("rst_mid");
    manual_data = 32'h5555_5555; manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    @(negedge clk);
    check_reset("late_ack");

    do_acc(1'b1, 32'h50, 1'b0, 32'h0, 4'hF, 32'h6666_6666, 0, 32'h6666_6666, 1'b0);

    repeat (3) @(negedge clk);
    chk("cmdq_empty", cmdq.size(), 0);
    chk("hitq_empty", hitq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
